// File: rtl/rfid_read_sequencer_if.sv
// Host-side handshake bundle of the RFID read sequencer: start request,
// busy indication and the frame/status hand-off with its valid/ack pair.
interface rfid_read_sequencer_if #(
    parameter int FRAME_BITS = 96
) ();
    logic                  start;
    logic                  busy;
    logic [FRAME_BITS-1:0] frame_data;
    logic [7:0]            bit_count;
    logic [1:0]            status;
    logic                  frame_valid;
    logic                  frame_ack;

    // Host side: requests reads and consumes frames.
    modport master (
        output start,
        output frame_ack,
        input  busy,
        input  frame_data,
        input  bit_count,
        input  status,
        input  frame_valid
    );

    // Sequencer side: accepts requests and presents frames.
    modport slave (
        input  start,
        input  frame_ack,
        output busy,
        output frame_data,
        output bit_count,
        output status,
        output frame_valid
    );
endinterface

// File: rtl/rfid_read_sequencer.sv
// Owns one read transaction of the FSK Manchester demodulator: clears the
// demodulator, shifts in one decoded bit per trigger toggle, closes the frame
// on full length, postamble or inactivity, and hands it to the host.
module rfid_read_sequencer #(
    parameter int FRAME_BITS     = 96,
    parameter int ARM_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                  sqwv,
    input  logic                  manual,
    input  logic                  bit_in,
    input  logic                  bit_toggle,
    input  logic                  demod_done,
    output logic                  demod_clr,
    rfid_read_sequencer_if.slave  host
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        COLLECT = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam int ARM_W = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST   = ARM_W'(ARM_CYCLES - 1);
    localparam logic [7:0]       FULL_COUNT = 8'(FRAME_BITS);
    localparam logic [23:0]      TO_LAST    = 24'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_SHORT   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    state_t                state_reg, state_next;
    logic [ARM_W-1:0]      arm_cnt_reg, arm_cnt_next;
    logic [FRAME_BITS-1:0] frame_data_reg, frame_data_next;
    logic [7:0]            bit_count_reg, bit_count_next;
    logic [1:0]            status_reg, status_next;
    logic [23:0]           timeout_reg, timeout_next;
    logic                  prev_tog_reg;
    logic                  demod_clr_reg;
    logic                  busy_reg;
    logic                  frame_valid_reg;
    logic                  tog_evt;

    // Any level change of the demodulator trigger is one new bit.
    assign tog_evt = bit_toggle ^ prev_tog_reg;

    // Next-state and datapath updates; exits are judged on post-capture values
    // so a bit arriving together with postamble or timeout is kept.
    always_comb begin
        state_next      = state_reg;
        arm_cnt_next    = arm_cnt_reg;
        frame_data_next = frame_data_reg;
        bit_count_next  = bit_count_reg;
        status_next     = status_reg;
        timeout_next    = timeout_reg;
        case (state_reg)
            IDLE: begin
                frame_data_next = '0;
                bit_count_next  = '0;
                status_next     = ST_OK;
                timeout_next    = '0;
                arm_cnt_next    = '0;
                if (host.start) begin
                    state_next = ARM;
                end
            end
            ARM: begin
                if (arm_cnt_reg == ARM_LAST) begin
                    state_next = COLLECT;
                end else begin
                    arm_cnt_next = arm_cnt_reg + 1'b1;
                end
            end
            COLLECT: begin
                if (tog_evt) begin
                    frame_data_next = {frame_data_reg[FRAME_BITS-2:0], bit_in};
                    bit_count_next  = bit_count_reg + 8'd1;
                    timeout_next    = '0;
                end else if (timeout_reg != 24'hFF_FFFF) begin
                    timeout_next = timeout_reg + 24'd1;
                end
                if (bit_count_next == FULL_COUNT) begin
                    state_next  = OUT;
                    status_next = ST_OK;
                end else if (demod_done) begin
                    state_next  = OUT;
                    status_next = ST_SHORT;
                end else if (!tog_evt && timeout_next >= TO_LAST) begin
                    state_next  = OUT;
                    status_next = ST_TIMEOUT;
                end
            end
            OUT: begin
                if (host.frame_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and registered outputs; the manual reset overrides everything.
    always_ff @(posedge sqwv) begin
        if (manual) begin
            state_reg       <= IDLE;
            arm_cnt_reg     <= '0;
            frame_data_reg  <= '0;
            bit_count_reg   <= '0;
            status_reg      <= ST_OK;
            timeout_reg     <= '0;
            prev_tog_reg    <= 1'b0;
            demod_clr_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            frame_valid_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            arm_cnt_reg     <= arm_cnt_next;
            frame_data_reg  <= frame_data_next;
            bit_count_reg   <= bit_count_next;
            status_reg      <= status_next;
            timeout_reg     <= timeout_next;
            prev_tog_reg    <= bit_toggle;
            demod_clr_reg   <= (state_next == ARM);
            busy_reg        <= (state_next != IDLE);
            frame_valid_reg <= (state_next == OUT);
        end
    end

    assign demod_clr        = demod_clr_reg;
    assign host.busy        = busy_reg;
    assign host.frame_data  = frame_data_reg;
    assign host.bit_count   = bit_count_reg;
    assign host.status      = status_reg;
    assign host.frame_valid = frame_valid_reg;

endmodule

// File: tb/tb_rfid_read_sequencer.sv
// Directed bench for rfid_read_sequencer: full, short and timed-out frames,
// priority corner cases, reset mid-read and output hold while unacknowledged.
module tb_rfid_read_sequencer;

    localparam int FB  = 96;
    localparam int ARM = 4;
    localparam int TO  = 20000;

    logic sqwv = 1'b0;
    logic manual;
    logic bit_in;
    logic bit_toggle;
    logic demod_done;
    logic demod_clr;

    int checks   = 0;
    int failures = 0;

    rfid_read_sequencer_if #(.FRAME_BITS(FB)) host ();

    rfid_read_sequencer #(
        .FRAME_BITS    (FB),
        .ARM_CYCLES    (ARM),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .sqwv      (sqwv),
        .manual    (manual),
        .bit_in    (bit_in),
        .bit_toggle(bit_toggle),
        .demod_done(demod_done),
        .demod_clr (demod_clr),
        .host      (host)
    );

    always #5 sqwv = ~sqwv;

    // Advance past one rising edge; outputs are then stable until the next.
    task automatic tick();
        @(posedge sqwv);
        #1;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_in     = b;
        bit_toggle = ~bit_toggle;
        tick();
        repeat (gap - 1) tick();
    endtask

    task automatic do_start();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        repeat (ARM) tick();
    endtask

    task automatic do_ack();
        host.frame_ack = 1'b1;
        tick();
        host.frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        manual = 1'b1;
        tick();
        tick();
        manual = 1'b0;
        checks++;
        if ({host.busy, demod_clr, host.frame_valid, host.status, host.bit_count} !== 13'd0) begin
            failures++;
            $display("FAIL reset_ctrl got=%h exp=0", {host.busy, demod_clr, host.frame_valid, host.status, host.bit_count});
        end
        checks++;
        if (host.frame_data !== '0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", host.frame_data);
        end
        $display("txn reset done");
    endtask

    task automatic test_full_frame();
        logic [FB-1:0] exp_data;
        exp_data = {48{2'b10}};
        repeat (5) tick();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        for (int k = 0; k < ARM; k++) begin
            checks++;
            if ({demod_clr, host.busy} !== 2'b11) begin
                failures++;
                $display("FAIL arm_clr_%0d got=%b exp=11", k, {demod_clr, host.busy});
            end
            tick();
        end
        checks++;
        if ({demod_clr, host.busy} !== 2'b01) begin
            failures++;
            $display("FAIL arm_end got=%b exp=01", {demod_clr, host.busy});
        end
        for (int i = 0; i < FB; i++) begin
            send_bit((i % 2) == 0, 1);
            if (i == 0) begin
                checks++;
                if (host.bit_count !== 8'd1) begin
                    failures++;
                    $display("FAIL first_bit_count got=%0d exp=1", host.bit_count);
                end
            end
            if (i == FB - 2) begin
                checks++;
                if ({host.frame_valid, host.bit_count} !== {1'b0, 8'd95}) begin
                    failures++;
                    $display("FAIL pre_last got=%h exp=05f", {host.frame_valid, host.bit_count});
                end
            end
            if (i < FB - 1) repeat (49) tick();
        end
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b00, 8'd96}) begin
            failures++;
            $display("FAIL full_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b00, 8'd96});
        end
        checks++;
        if (host.frame_data !== exp_data) begin
            failures++;
            $display("FAIL full_data got=%h exp=%h", host.frame_data, exp_data);
        end
        do_ack();
        checks++;
        if ({host.frame_valid, host.busy} !== 2'b00) begin
            failures++;
            $display("FAIL full_ack got=%b exp=00", {host.frame_valid, host.busy});
        end
        $display("txn full_frame status=%0d count=%0d", 0, FB);
    endtask

    task automatic test_short();
        logic [FB-1:0] exp_data;
        exp_data = {56'd0, {40{1'b1}}};
        do_start();
        for (int i = 0; i < 40; i++) send_bit(1'b1, 5);
        demod_done = 1'b1;
        tick();
        demod_done = 1'b0;
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b01, 8'd40}) begin
            failures++;
            $display("FAIL short_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b01, 8'd40});
        end
        checks++;
        if (host.frame_data !== exp_data) begin
            failures++;
            $display("FAIL short_data got=%h exp=%h", host.frame_data, exp_data);
        end
        do_ack();
        $display("txn short status=1 count=40");
    endtask

    task automatic test_timeout();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        repeat (ARM + TO - 2) tick();
        checks++;
        if (host.frame_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_early got=%b exp=0", host.frame_valid);
        end
        tick();
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b10, 8'd0}) begin
            failures++;
            $display("FAIL timeout_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b10, 8'd0});
        end
        do_ack();
        $display("txn timeout status=2 count=0");
    endtask

    task automatic test_last_bit_with_done();
        logic [FB-1:0] exp_data;
        exp_data = {48{2'b01}};
        do_start();
        for (int i = 0; i < FB - 1; i++) send_bit((i % 2) == 1, 2);
        demod_done = 1'b1;
        send_bit(1'b1, 1);
        demod_done = 1'b0;
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b00, 8'd96}) begin
            failures++;
            $display("FAIL lastdone_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b00, 8'd96});
        end
        checks++;
        if (host.frame_data !== exp_data) begin
            failures++;
            $display("FAIL lastdone_data got=%h exp=%h", host.frame_data, exp_data);
        end
        do_ack();
        $display("txn last_bit_with_done status=0 count=96");
    endtask

    task automatic test_start_ignored();
        logic [7:0] pat;
        pat = 8'hC5;
        host.start = 1'b1;
        tick();
        tick();
        host.start = 1'b0;
        repeat (ARM - 1) tick();
        for (int i = 0; i < 8; i++) begin
            send_bit(pat[7-i], 3);
            if (i == 3) begin
                host.start = 1'b1;
                tick();
                host.start = 1'b0;
            end
        end
        demod_done = 1'b1;
        tick();
        demod_done = 1'b0;
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b01, 8'd8}) begin
            failures++;
            $display("FAIL ign_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b01, 8'd8});
        end
        checks++;
        if (host.frame_data !== 96'hC5) begin
            failures++;
            $display("FAIL ign_data got=%h exp=c5", host.frame_data);
        end
        do_ack();
        tick();
        tick();
        checks++;
        if (host.busy !== 1'b0) begin
            failures++;
            $display("FAIL ign_not_queued got=%b exp=0", host.busy);
        end
        $display("txn start_ignored status=1 count=8");
    endtask

    task automatic test_arm_toggle();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        bit_in     = 1'b1;
        bit_toggle = ~bit_toggle;
        repeat (ARM) tick();
        send_bit(1'b0, 2);
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        demod_done = 1'b1;
        tick();
        demod_done = 1'b0;
        checks++;
        if ({host.status, host.bit_count} !== {2'b01, 8'd3}) begin
            failures++;
            $display("FAIL armtog_count got=%h exp=%h", {host.status, host.bit_count}, {2'b01, 8'd3});
        end
        checks++;
        if (host.frame_data !== 96'd2) begin
            failures++;
            $display("FAIL armtog_data got=%h exp=2", host.frame_data);
        end
        do_ack();
        $display("txn arm_toggle status=1 count=3");
    endtask

    task automatic test_reset_mid_collect();
        logic [FB-1:0] pat;
        pat = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
        do_start();
        for (int i = 0; i < 30; i++) send_bit(i[0], 3);
        manual = 1'b1;
        tick();
        manual = 1'b0;
        checks++;
        if ({host.busy, demod_clr, host.frame_valid, host.status, host.bit_count} !== 13'd0) begin
            failures++;
            $display("FAIL midrst_ctrl got=%h exp=0", {host.busy, demod_clr, host.frame_valid, host.status, host.bit_count});
        end
        checks++;
        if (host.frame_data !== '0) begin
            failures++;
            $display("FAIL midrst_data got=%h exp=0", host.frame_data);
        end
        do_start();
        for (int i = 0; i < FB; i++) send_bit(pat[FB-1-i], (i == FB - 1) ? 1 : 2);
        checks++;
        if ({host.frame_valid, host.status, host.bit_count} !== {1'b1, 2'b00, 8'd96}) begin
            failures++;
            $display("FAIL midrst_status got=%h exp=%h", {host.frame_valid, host.status, host.bit_count}, {1'b1, 2'b00, 8'd96});
        end
        checks++;
        if (host.frame_data !== pat) begin
            failures++;
            $display("FAIL midrst_data2 got=%h exp=%h", host.frame_data, pat);
        end
        do_ack();
        $display("txn reset_mid_collect status=0 count=96");
    endtask

    task automatic test_hold();
        logic [FB-1:0] pat;
        pat = 96'h0F1E_2D3C_4B5A_6978_8796_A5B4;
        do_start();
        for (int i = 0; i < FB; i++) send_bit(pat[FB-1-i], 1);
        for (int i = 0; i < 100; i++) begin
            bit_toggle = ~bit_toggle;
            bit_in     = 1'($urandom);
            demod_done = i[0];
            tick();
            checks++;
            if ({host.frame_valid, host.status, host.bit_count, host.frame_data} !== {1'b1, 2'b00, 8'd96, pat}) begin
                failures++;
                $display("FAIL hold_%0d got=%h exp=%h", i, {host.frame_valid, host.status, host.bit_count, host.frame_data}, {1'b1, 2'b00, 8'd96, pat});
            end
        end
        demod_done = 1'b0;
        do_ack();
        $display("txn hold status=0 count=96");
    endtask

    task automatic test_back_to_back();
        do_start();
        send_bit(1'b1, 2);
        send_bit(1'b1, 2);
        demod_done = 1'b1;
        tick();
        demod_done = 1'b0;
        checks++;
        if ({host.status, host.bit_count, host.frame_data} !== {2'b01, 8'd2, 96'd3}) begin
            failures++;
            $display("FAIL b2b_first got=%h exp=%h", {host.status, host.bit_count, host.frame_data}, {2'b01, 8'd2, 96'd3});
        end
        do_ack();
        host.start = 1'b1;
        tick();
        host.start = 1'b0;
        checks++;
        if ({host.busy, demod_clr, host.frame_valid} !== 3'b110) begin
            failures++;
            $display("FAIL b2b_accept got=%b exp=110", {host.busy, demod_clr, host.frame_valid});
        end
        repeat (ARM) tick();
        demod_done = 1'b1;
        tick();
        demod_done = 1'b0;
        checks++;
        if ({host.frame_valid, host.status, host.bit_count, host.frame_data} !== {1'b1, 2'b01, 8'd0, 96'd0}) begin
            failures++;
            $display("FAIL b2b_second got=%h exp=%h", {host.frame_valid, host.status, host.bit_count, host.frame_data}, {1'b1, 2'b01, 8'd0, 96'd0});
        end
        do_ack();
        $display("txn back_to_back status=1 count=0");
    endtask

    // Absolute bound on the run so it can never hang.
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        manual         = 1'b1;
        bit_in         = 1'b0;
        bit_toggle     = 1'b0;
        demod_done     = 1'b0;
        host.start     = 1'b0;
        host.frame_ack = 1'b0;
        test_reset();
        test_full_frame();
        test_short();
        test_timeout();
        test_last_bit_with_done();
        test_start_ignored();
        test_arm_toggle();
        test_reset_mid_collect();
        test_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rfid_read_sequencer.md
# rfid_read_sequencer

Sequencer that owns one read transaction of the FSK Manchester demodulator. On a host `start` it pulses the demodulator's clear input. It then collects the decoded bit stream, one bit per toggle of the demodulator's trigger, into a frame register. It closes the transaction on a full frame, early postamble, or inactivity timeout, and hands the frame and a status code to the host over a valid/ack handshake. It sits between the demodulator output and the host/UART side of the reader.

## Interface
- FRAME_BITS, 96, bits per complete tag frame; must be 2..255.
- ARM_CYCLES, 4, width of the demodulator clear pulse in cycles; must be ≥1.
- TIMEOUT_CYCLES, 20000, cycles without a bit before the read is abandoned; must be ≥2 and < 2^24.
- sqwv  in  1  clock; the same carrier-derived square wave that clocks the demodulator.
- manual  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request to begin a read; sampled only in IDLE.
- bit_in  in  1  decoded bit from the demodulator, valid when its trigger toggles.
- bit_toggle  in  1  demodulator trigger; every level change means one new bit.
- demod_done  in  1  demodulator postamble flag (level).
- demod_clr  out  1  clear pulse to the demodulator.
- busy  out  1  high in any state except IDLE.
- frame_data  out  FRAME_BITS  collected bits; first bit received is the most significant of the received bits.
- bit_count  out  8  number of bits captured in the current or last frame.
- status  out  2  00 = ok (full frame), 01 = short (postamble before full frame), 10 = timeout.
- frame_valid  out  1  frame/status available; held until acked.
- frame_ack  in  1  host consumes the frame; only meaningful while frame_valid = 1.

## Operation
- States: IDLE, ARM, COLLECT, OUT.
- IDLE:
  - start = 1 → ARM.
  - Clear frame_data, bit_count, status and the timeout counter.
- ARM:
  - demod_clr = 1 for exactly ARM_CYCLES cycles, then → COLLECT.
  - The registered copy of bit_toggle, prev_tog, is loaded every ARM cycle, so a toggle caused by the clear is never counted.
- COLLECT:
  - Edge detect: tog_evt = bit_toggle ^ prev_tog; prev_tog updates every cycle.
  - On tog_evt: frame_data ← {frame_data[FRAME_BITS-2:0], bit_in}, bit_count += 1, timeout counter ← 0.
  - Otherwise the timeout counter += 1 (24-bit, saturating).
- COLLECT exits, priority order, evaluated on post-capture values:
  - bit_count reaches FRAME_BITS → OUT with status 00.
  - Else demod_done = 1 → OUT with status 01.
  - Else the timeout counter reaches TIMEOUT_CYCLES − 1 without tog_evt → OUT with status 10.
- OUT:
  - frame_valid = 1; frame_data, bit_count and status are frozen.
  - bit_in, bit_toggle and demod_done are ignored.
  - frame_ack = 1 → IDLE.
- start outside IDLE is ignored; it is not queued.
- A short or timed-out frame keeps its partial bits right-aligned; the upper bits are 0.

## Timing
- Reset (manual = 1 at a sqwv rising edge) has priority over all other inputs, in every state including mid-ARM and mid-COLLECT.
- Reset values: state IDLE, demod_clr 0, busy 0, frame_valid 0, frame_data 0, bit_count 0, status 00, prev_tog 0, timeout counter 0.
- All outputs are registered.
- start high at edge N:
  - busy = 1 and demod_clr = 1 from N+1 through N+ARM_CYCLES.
  - COLLECT from N+ARM_CYCLES+1.
- tog_evt and demod_done at the same edge: the bit is captured first, then the exit is checked. A last bit arriving with demod_done therefore yields status 00 when the frame fills.
- tog_evt at the edge where timeout would fire: the bit wins and the counter clears.
- Final bit at edge k: frame_valid = 1 from k+1.
- frame_ack at edge m: frame_valid = 0 and busy = 0 from m+1.
- start at m+1 is accepted; back-to-back reads are allowed.
- Latency from a toggle to its visibility in bit_count is 1 cycle.

## Test plan
- Reset, start at cycle 10, then 96 alternating bits (1,0,1,…), one toggle every 50 cycles:
  - demod_clr is high for cycles 11–14.
  - frame_valid = 1 one cycle after the 96th toggle.
  - status 00, bit_count 96, frame_data = 0xAAAA…AA.
  - frame_ack → IDLE the next cycle.
- 40 bits of 1, then demod_done = 1:
  - status 01, bit_count 40, frame_data = 2^40 − 1.
- Start with no toggles:
  - frame_valid = 1 with status 10 and bit_count 0 exactly ARM_CYCLES + TIMEOUT_CYCLES cycles after start.
- 96th toggle in the same cycle as demod_done → status 00.
- Start pulses while busy are ignored: a single frame results.
- A bit_toggle change during ARM is not counted.
- manual asserted mid-COLLECT (after 30 bits):
  - All outputs return to reset values the next cycle.
  - A new start then produces a clean 96-bit frame.
- frame_valid held for 100 cycles without ack:
  - Data and status are stable.
  - Extra toggles and demod_done are ignored.
